// File: rtl/mac_port_table.sv
// rtl/mac_port_table.sv - hashed direct-mapped MAC learning/forwarding table
// One request in flight: IDLE -> LOOKUP -> LEARN -> RESP.
module mac_port_table #(
   parameter int PORT_TABLE_ADDR_LEN = 3,
   parameter int AGE_BITS            = 4,
   parameter int PORT_NUM            = 4
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [47:0]         req_dst_mac,
   input  logic [47:0]         req_src_mac,
   input  logic [1:0]          req_port,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [PORT_NUM-1:0] resp_port_mask,
   output logic                resp_hit,
   input  logic                age_tick,
   input  logic                flush,
   input  logic [PORT_NUM-1:0] mask_port
);

   localparam int ENTRIES = 1 << PORT_TABLE_ADDR_LEN;

   typedef logic [PORT_TABLE_ADDR_LEN-1:0] idx_t;
   typedef enum logic [1:0] {IDLE, LOOKUP, LEARN, RESP} state_t;

   state_t                state;
   logic [47:0]           lat_dst;
   logic [47:0]           lat_src;
   logic [1:0]            lat_port;

   logic                  ent_valid [ENTRIES];
   logic [47:0]           ent_mac   [ENTRIES];
   logic [1:0]            ent_port  [ENTRIES];
   logic [AGE_BITS-1:0]   ent_age   [ENTRIES];

   idx_t                  dst_idx;
   idx_t                  src_idx;
   logic                  lookup_hit;
   logic [PORT_NUM-1:0]   lookup_mask;
   logic [PORT_NUM-1:0]   all_mask;
   logic                  learn_we;

   // Bit i of the MAC lands in slice i/L at position i%L; XOR-folding all slices.
   function automatic idx_t hash_idx(input logic [47:0] mac);
      idx_t h;
      h = '0;
      for (int i = 0; i < 48; i++) begin
         h[i % PORT_TABLE_ADDR_LEN] = h[i % PORT_TABLE_ADDR_LEN] ^ mac[i];
      end
      return h;
   endfunction

   function automatic logic [PORT_NUM-1:0] port_onehot(input logic [1:0] p);
      logic [PORT_NUM-1:0] r;
      r    = '0;
      r[p] = 1'b1;
      return r;
   endfunction

   // A flush during LOOKUP forces a miss so the response never names a stale port.
   always_comb begin
      dst_idx    = hash_idx(lat_dst);
      src_idx    = hash_idx(lat_src);
      all_mask   = ~mask_port & ~port_onehot(lat_port);
      lookup_hit = !lat_dst[40] && !flush && ent_valid[dst_idx]
                   && (ent_mac[dst_idx] == lat_dst);
      if (!lookup_hit)
         lookup_mask = all_mask;
      else if (ent_port[dst_idx] == lat_port)
         lookup_mask = '0;
      else
         lookup_mask = port_onehot(ent_port[dst_idx]) & ~mask_port;
      learn_we = (state == LEARN) && !lat_src[40];
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state          <= IDLE;
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         resp_port_mask <= '0;
         resp_hit       <= 1'b0;
         lat_dst        <= '0;
         lat_src        <= '0;
         lat_port       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_dst   <= req_dst_mac;
                  lat_src   <= req_src_mac;
                  lat_port  <= req_port;
                  req_ready <= 1'b0;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               resp_port_mask <= lookup_mask;
               resp_hit       <= lookup_hit;
               state          <= LEARN;
            end
            LEARN: begin
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Priority per entry: flush, then learn write, then aging.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ent_valid[i] <= 1'b0;
            ent_mac[i]   <= '0;
            ent_port[i]  <= '0;
            ent_age[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (flush) begin
               ent_valid[i] <= 1'b0;
            end else if (learn_we && (src_idx == idx_t'(i))) begin
               ent_valid[i] <= 1'b1;
               ent_mac[i]   <= lat_src;
               ent_port[i]  <= lat_port;
               ent_age[i]   <= '1;
            end else if (age_tick && ent_valid[i]) begin
               if (ent_age[i] == '0)
                  ent_valid[i] <= 1'b0;
               else
                  ent_age[i] <= ent_age[i] - 1'b1;
            end
         end
      end
   end

endmodule
